vga_timing_monitor: RTL
=======================

Name: vga_timing_monitor

Overview:
- Receive-side counterpart of the VGA timing generator: samples hsync, vsync and disp_enable and measures line and frame periods.
- Recovers pixel X/Y coordinates and declares lock when the incoming timing matches the configured mode.
- Sits on the capture/verification side of the video path: feeds pattern checkers and frame grabbers, and gives benches self-checking timing.

Parameters:
- H_DISP, 640, expected active pixels per line
- H_TOTAL, 800, expected clk cycles per line
- V_DISP, 480, expected active lines per frame
- V_TOTAL, 525, expected lines per frame
- HS_POL, 0, active level of hsync
- VS_POL, 0, active level of vsync
- LOCK_FRAMES, 2, consecutive good frames required for lock (1..15)
- CW, 12, counter / coordinate width

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  reset
- hsync  in  1  horizontal sync, polarity HS_POL
- vsync  in  1  vertical sync, polarity VS_POL
- de  in  1  display enable, active high
- x_out  out  CW  column of current active pixel
- y_out  out  CW  row of current active pixel
- pix_valid  out  1  x_out/y_out valid for this cycle
- frame_start  out  1  one-cycle pulse on vsync leading edge
- h_total_meas  out  CW  last measured line period
- v_total_meas  out  CW  last measured frame period, in lines
- locked  out  1  timing matches the configured mode
- err  out  1  one-cycle pulse on mismatch while locked

Behaviour:
- Reset: clk is the clock; rst_n is an asynchronous, active-low reset. All outputs, counters and the input pipeline reset to 0; FSM resets to SEARCH.
- Input stage: hsync, vsync and de are registered once (stage S1). Leading edge = S1 at active level while the previous S1 sample was inactive.
- hcnt:
  - Cleared to 0 on the cycle after an hsync leading edge; otherwise increments, saturating at all-ones.
  - On each leading edge, h_total_meas <= hcnt+1 (saturating). This equals the number of clk cycles between consecutive leading edges.
- vcnt:
  - Increments on each hsync leading edge and clears on a vsync leading edge.
  - On a vsync leading edge, v_total_meas <= vcnt+1.
  - If an hsync and vsync leading edge coincide, the line is still checked and the vsync clear wins.
- Coordinates:
  - x counts S1 de-high cycles and clears on the first de-high cycle of each run.
  - y increments on each de falling edge and clears on a vsync leading edge.
  - Outputs are registered, so pix_valid = de delayed 2 clk. The first active pixel of a frame reports x_out=0, y_out=0.
  - When pix_valid=0, x_out/y_out hold their last value.
- frame_start: asserted 2 clk after the raw vsync leading edge.
- Line check: each hsync leading edge compares hcnt+1 against H_TOTAL. A mismatch, including saturation from a missing hsync, sets a per-frame bad flag.
- Frame check: on each vsync leading edge, the frame is good iff the bad flag is clear and vcnt+1 == V_TOTAL. The bad flag then clears.
- FSM:
  - SEARCH: no checks. The first vsync leading edge moves to VERIFY with good_cnt=0, and the partial frame is discarded.
  - VERIFY: a good frame increments good_cnt; reaching LOCK_FRAMES moves to LOCKED. A bad frame resets good_cnt to 0 and stays in VERIFY.
  - LOCKED: locked=1. The first line mismatch (at that hsync edge) or frame mismatch pulses err for one cycle, drops locked on the same cycle and moves to SEARCH.
- err never asserts outside LOCKED.
- Reset mid-frame: all state is discarded; lock re-acquisition needs 1 partial frame plus LOCK_FRAMES full frames.
- Arithmetic: all compares are CW-bit unsigned; there is no wrap-around anywhere, all counters saturate.

Optional Feature:
- Macro: VGA_MON_DE_CHECK_EN.
- Defined:
  - Each de run length must equal H_DISP, checked at the de falling edge.
  - The number of de runs per frame must equal V_DISP, checked at the vsync edge.
  - Either failure sets the frame bad flag; in LOCKED a run-length failure pulses err immediately.
- Undefined: de drives only coordinates and pix_valid; lock depends on sync periods alone.

Test Plan:
- 640x480 generator timing (800x525, sync active low), LOCK_FRAMES=2 -> locked=1 at the vsync edge ending the 2nd full frame after the first vsync; h_total_meas=800, v_total_meas=525.
- Locked stream, sample first/last active pixel -> (x_out,y_out)=(0,0) then (639,479), pix_valid exactly 2 clk after de, 307200 valid cycles per frame.
- Locked, one line shortened to 799 cycles -> err pulses once at that hsync edge, locked=0, h_total_meas=799, relock after partial + 2 good frames.
- Locked, hsync held inactive -> hcnt saturates at 4095, err at the next hsync edge; frame_start still pulses on vsync.
- rst_n low for 3 cycles mid-line while locked -> all outputs 0 asynchronously, FSM SEARCH, no err pulse during or after reset.
- With VGA_MON_DE_CHECK_EN, de run of 639 on one line while locked -> err at that de falling edge; without the macro -> locked stays 1.

Source files
------------

// File: rtl/vga_timing_monitor_if.sv
// Sync inputs and measurement outputs of the VGA timing monitor.
interface vga_timing_monitor_if #(
  parameter int CW = 12
);
  logic          hsync;
  logic          vsync;
  logic          de;
  logic [CW-1:0] x_out;
  logic [CW-1:0] y_out;
  logic          pix_valid;
  logic          frame_start;
  logic [CW-1:0] h_total_meas;
  logic [CW-1:0] v_total_meas;
  logic          locked;
  logic          err;

  modport master (
    output hsync, vsync, de,
    input  x_out, y_out, pix_valid, frame_start,
           h_total_meas, v_total_meas, locked, err
  );

  modport slave (
    input  hsync, vsync, de,
    output x_out, y_out, pix_valid, frame_start,
           h_total_meas, v_total_meas, locked, err
  );
endinterface

// File: rtl/vga_timing_monitor.sv
// Receive-side VGA timing monitor: measures line/frame periods, recovers pixel
// coordinates and locks to the configured mode. Define VGA_MON_DE_CHECK_EN to also verify de geometry.
module vga_timing_monitor #(
  parameter int H_DISP      = 640,
  parameter int H_TOTAL     = 800,
  parameter int V_DISP      = 480,
  parameter int V_TOTAL     = 525,
  parameter bit HS_POL      = 1'b0,
  parameter bit VS_POL      = 1'b0,
  parameter int LOCK_FRAMES = 2,
  parameter int CW          = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  vga_timing_monitor_if.slave mon
);
  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  localparam logic [CW-1:0] ONE       = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] H_TOTAL_C = CW'(H_TOTAL);
  localparam logic [CW-1:0] V_TOTAL_C = CW'(V_TOTAL);
  localparam logic [3:0]    LOCK_C    = 4'(LOCK_FRAMES);

  if (LOCK_FRAMES < 1 || LOCK_FRAMES > 15 || H_DISP > H_TOTAL || V_DISP > V_TOTAL) begin : g_cfg_err
    $error("vga_timing_monitor: inconsistent mode parameters");
  end

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + ONE;
  endfunction

  logic          hs_s1_q, hs_s1_d, hs_s2_q, hs_s2_d;
  logic          vs_s1_q, vs_s1_d, vs_s2_q, vs_s2_d;
  logic          de_s1_q, de_s1_d, de_s2_q, de_s2_d;
  logic [CW-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [CW-1:0] h_total_meas_q, h_total_meas_d, v_total_meas_q, v_total_meas_d;
  logic [CW-1:0] x_out_q, x_out_d, y_out_q, y_out_d, y_cnt_q, y_cnt_d;
  logic          pix_valid_q, pix_valid_d, frame_start_q, frame_start_d;
  logic          bad_q, bad_d;
  logic          hs_lead, vs_lead, de_rise, de_fall;
  logic [CW-1:0] h_meas, v_meas;
  logic          line_bad, run_bad, runs_bad, frame_bad;

  state_t     state_q;
  logic [3:0] good_cnt_q;
  logic       locked_q, err_q;

  // Stage S1: syncs normalised to active-high, plus the previous S1 sample for edge detection
  always_comb begin
    hs_s1_d = (mon.hsync == HS_POL);
    vs_s1_d = (mon.vsync == VS_POL);
    de_s1_d = mon.de;
    hs_s2_d = hs_s1_q;
    vs_s2_d = vs_s1_q;
    de_s2_d = de_s1_q;
  end

  assign hs_lead  = hs_s1_q & ~hs_s2_q;
  assign vs_lead  = vs_s1_q & ~vs_s2_q;
  assign de_rise  = de_s1_q & ~de_s2_q;
  assign de_fall  = ~de_s1_q & de_s2_q;
  assign h_meas   = sat_inc(hcnt_q);
  assign v_meas   = sat_inc(vcnt_q);
  assign line_bad = hs_lead & (h_meas != H_TOTAL_C);

`ifdef VGA_MON_DE_CHECK_EN
  localparam logic [CW-1:0] H_DISP_C = CW'(H_DISP);
  localparam logic [CW-1:0] V_DISP_C = CW'(V_DISP);
  logic [CW-1:0] runs_q, runs_d;

  // x_out_q still holds the last column of the run when the falling edge is seen
  always_comb begin
    runs_d   = vs_lead ? '0 : (de_rise ? sat_inc(runs_q) : runs_q);
    run_bad  = de_fall & (sat_inc(x_out_q) != H_DISP_C);
    runs_bad = (runs_q != V_DISP_C);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) runs_q <= '0;
    else        runs_q <= runs_d;
  end
`else
  assign run_bad  = 1'b0;
  assign runs_bad = 1'b0;
`endif

  assign frame_bad = bad_q | line_bad | run_bad | runs_bad | (v_meas != V_TOTAL_C);

  // Stage S2: counters, measurements and registered coordinates
  always_comb begin
    hcnt_d         = hs_lead ? '0 : sat_inc(hcnt_q);
    h_total_meas_d = hs_lead ? h_meas : h_total_meas_q;
    vcnt_d         = vs_lead ? '0 : (hs_lead ? v_meas : vcnt_q);
    v_total_meas_d = vs_lead ? v_meas : v_total_meas_q;
    bad_d          = vs_lead ? 1'b0 : (bad_q | line_bad | run_bad);
    x_out_d        = de_s1_q ? (de_rise ? '0 : sat_inc(x_out_q)) : x_out_q;
    y_cnt_d        = vs_lead ? '0 : (de_fall ? sat_inc(y_cnt_q) : y_cnt_q);
    y_out_d        = de_s1_q ? y_cnt_q : y_out_q;
    pix_valid_d    = de_s1_q;
    frame_start_d  = vs_lead;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_s1_q        <= 1'b0;
      hs_s2_q        <= 1'b0;
      vs_s1_q        <= 1'b0;
      vs_s2_q        <= 1'b0;
      de_s1_q        <= 1'b0;
      de_s2_q        <= 1'b0;
      hcnt_q         <= '0;
      vcnt_q         <= '0;
      h_total_meas_q <= '0;
      v_total_meas_q <= '0;
      bad_q          <= 1'b0;
      x_out_q        <= '0;
      y_out_q        <= '0;
      y_cnt_q        <= '0;
      pix_valid_q    <= 1'b0;
      frame_start_q  <= 1'b0;
    end else begin
      hs_s1_q        <= hs_s1_d;
      hs_s2_q        <= hs_s2_d;
      vs_s1_q        <= vs_s1_d;
      vs_s2_q        <= vs_s2_d;
      de_s1_q        <= de_s1_d;
      de_s2_q        <= de_s2_d;
      hcnt_q         <= hcnt_d;
      vcnt_q         <= vcnt_d;
      h_total_meas_q <= h_total_meas_d;
      v_total_meas_q <= v_total_meas_d;
      bad_q          <= bad_d;
      x_out_q        <= x_out_d;
      y_out_q        <= y_out_d;
      y_cnt_q        <= y_cnt_d;
      pix_valid_q    <= pix_valid_d;
      frame_start_q  <= frame_start_d;
    end
  end

  // Lock FSM: the first vsync edge out of SEARCH only aligns, it never counts a frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SEARCH;
      good_cnt_q <= '0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        SEARCH: begin
          if (vs_lead) begin
            state_q    <= VERIFY;
            good_cnt_q <= '0;
          end
        end
        VERIFY: begin
          if (vs_lead) begin
            if (frame_bad) begin
              good_cnt_q <= '0;
            end else if (good_cnt_q + 4'd1 >= LOCK_C) begin
              state_q    <= LOCKED;
              locked_q   <= 1'b1;
              good_cnt_q <= '0;
            end else begin
              good_cnt_q <= good_cnt_q + 4'd1;
            end
          end
        end
        LOCKED: begin
          if (line_bad || run_bad || (vs_lead && frame_bad)) begin
            state_q  <= SEARCH;
            locked_q <= 1'b0;
            err_q    <= 1'b1;
          end
        end
        default: begin
          state_q  <= SEARCH;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  assign mon.x_out        = x_out_q;
  assign mon.y_out        = y_out_q;
  assign mon.pix_valid    = pix_valid_q;
  assign mon.frame_start  = frame_start_q;
  assign mon.h_total_meas = h_total_meas_q;
  assign mon.v_total_meas = v_total_meas_q;
  assign mon.locked       = locked_q;
  assign mon.err          = err_q;
endmodule
